// File: rtl/regif_cpl_tx_if.sv
// TRN TX bus (64-bit Virtex-5 endpoint) between a TLP source and the core.
// master drives the frame, slave returns destination-ready.
interface regif_cpl_tx_if;
   logic [63:0] trn_td;
   logic [7:0]  trn_trem_n;
   logic        trn_tsof_n;
   logic        trn_teof_n;
   logic        trn_tsrc_rdy_n;
   logic        trn_tdst_rdy_n;

   modport master (
      output trn_td,
      output trn_trem_n,
      output trn_tsof_n,
      output trn_teof_n,
      output trn_tsrc_rdy_n,
      input  trn_tdst_rdy_n
   );

   modport slave (
      input  trn_td,
      input  trn_trem_n,
      input  trn_tsof_n,
      input  trn_teof_n,
      input  trn_tsrc_rdy_n,
      output trn_tdst_rdy_n
   );
endinterface

// File: rtl/regif_cpl_tx.sv
// Register-read completion sender: queues read results, wins the shared
// TX endpoint from the arbiter and emits 3DW-header CplD TLPs.
module regif_cpl_tx #(
   parameter int DEPTH     = 4,
   parameter int MAX_BURST = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          cfg_completer_id,
   input  logic                 rd_valid,
   output logic                 rd_ready,
   input  logic [15:0]          rd_reqid,
   input  logic [7:0]           rd_tag,
   input  logic [6:0]           rd_laddr,
   input  logic [31:0]          rd_data,
   input  logic                 trn,
   output logic                 reqep,
   output logic                 drvn,
   regif_cpl_tx_if.master       tx
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   localparam logic [CW-1:0] FULL  = CW'(DEPTH);
   localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      B0,
      B1
   } state_t;

   state_t state;

   logic [15:0] q_reqid [DEPTH];
   logic [7:0]  q_tag   [DEPTH];
   logic [6:0]  q_laddr [DEPTH];
   logic [31:0] q_data  [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [BW-1:0] burst;

   logic          push;
   logic          pop;
   logic          accept;
   logic          more;
   logic [63:0]   beat0;
   logic [63:0]   beat1;

   assign tx.trn_trem_n = 8'h00;

   assign push   = rd_valid & rd_ready;
   assign accept = ~tx.trn_tsrc_rdy_n & ~tx.trn_tdst_rdy_n;
   assign pop    = (state == B1) & accept;

   // Fmt/Type CplD, length 1; completer ID; status SC, BCM 0, byte count 4
   assign beat0 = {32'h4A00_0001, cfg_completer_id, 16'h0004};

   // beat1 is only sampled in B0, a full cycle after any push of this entry
   assign beat1 = {q_reqid[rd_ptr], q_tag[rd_ptr], 1'b0,
                   q_laddr[rd_ptr], q_data[rd_ptr]};

   always_comb begin
      count_next = count;
      unique case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   assign more = (count_next != '0) && (burst != BLAST);

   always_ff @(posedge clk) begin
      if (push) begin
         q_reqid[wr_ptr] <= rd_reqid;
         q_tag[wr_ptr]   <= rd_tag;
         q_laddr[wr_ptr] <= rd_laddr;
         q_data[wr_ptr]  <= rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         reqep             <= 1'b0;
         drvn              <= 1'b0;
         burst             <= '0;
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         rd_ready          <= 1'b1;
         tx.trn_td         <= '0;
         tx.trn_tsof_n     <= 1'b1;
         tx.trn_teof_n     <= 1'b1;
         tx.trn_tsrc_rdy_n <= 1'b1;
      end else begin
         count    <= count_next;
         rd_ready <= (count_next != FULL);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);

         unique case (state)
            IDLE: begin
               if (count != '0) begin
                  reqep <= 1'b1;
                  state <= REQ;
               end
            end
            REQ: begin
               if (trn) begin
                  reqep             <= 1'b0;
                  drvn              <= 1'b1;
                  burst             <= '0;
                  tx.trn_td         <= beat0;
                  tx.trn_tsof_n     <= 1'b0;
                  tx.trn_teof_n     <= 1'b1;
                  tx.trn_tsrc_rdy_n <= 1'b0;
                  state             <= B0;
               end
            end
            B0: begin
               if (accept) begin
                  tx.trn_td     <= beat1;
                  tx.trn_tsof_n <= 1'b1;
                  tx.trn_teof_n <= 1'b0;
                  state         <= B1;
               end
            end
            B1: begin
               if (accept) begin
                  if (more) begin
                     burst         <= burst + BW'(1);
                     tx.trn_td     <= beat0;
                     tx.trn_tsof_n <= 1'b0;
                     tx.trn_teof_n <= 1'b1;
                     state         <= B0;
                  end else begin
                     tx.trn_tsrc_rdy_n <= 1'b1;
                     tx.trn_teof_n     <= 1'b1;
                     drvn              <= 1'b0;
                     state             <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
